depth_scan_ctrl: RTL and testbench

Job sequencer for the depth-increase counter core. On a start command it reads a run of depth samples from a sample memory and streams them, raw or as 3-sample sliding-window sums, into the counter core. It clears the core between jobs, waits for the core's last flag, then latches and reports the count. It sits between the testbench/host command port and the counter core, and owns the core's reset and data inputs.

---
 rtl/depth_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_depth_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/depth_scan_ctrl.sv
// Job sequencer for the depth-increase counter core: fetches a run of samples,
// streams them raw or as 3-sample window sums, and reports the core's count.
module depth_scan_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  I_CLK,
    input  logic                  I_RSTN,
    input  logic                  I_START,
    input  logic [ADDR_WIDTH-1:0] I_BASE,
    input  logic [ADDR_WIDTH-1:0] I_LEN,
    input  logic                  I_WINDOW,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic [DATA_WIDTH-1:0] O_RESULT,
    output logic                  O_MEM_EN,
    output logic [ADDR_WIDTH-1:0] O_MEM_ADDR,
    input  logic [DATA_WIDTH-1:0] I_MEM_DATA,
    output logic                  O_CORE_RSTN,
    output logic [DATA_WIDTH-1:0] O_CORE_DATA,
    output logic                  O_CORE_LAST,
    input  logic [DATA_WIDTH-1:0] I_CORE_COUNT,
    input  logic                  I_CORE_LAST
);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q, len_q, idx_q;
    logic                  win_q;
    logic                  rd_vld_q, rd_last_q;
    logic [1:0]            smp_cnt_q;
    logic [DATA_WIDTH-1:0] s1_q, s2_q, core_data_q, result_q;
    logic                  core_last_q;
    logic                  degenerate, fetch_last;

    // A window of 3 needs at least three samples to produce a single sum.
    assign degenerate = (I_LEN == '0) || (I_WINDOW && (I_LEN < ADDR_WIDTH'(3)));
    assign fetch_last = (idx_q == (len_q - ADDR_WIDTH'(1)));

    always_ff @(posedge I_CLK) begin
        if (!I_RSTN) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (I_START) state_nxt = degenerate ? S_DONE : S_CLR;
            S_CLR:   state_nxt = S_FETCH;
            S_FETCH: if (fetch_last) state_nxt = S_DRAIN;
            S_DRAIN: if (I_CORE_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        O_BUSY      = 1'b0;
        O_DONE      = 1'b0;
        O_MEM_EN    = 1'b0;
        O_MEM_ADDR  = '0;
        O_CORE_RSTN = I_RSTN;
        case (state)
            S_CLR: begin
                O_BUSY      = 1'b1;
                O_CORE_RSTN = 1'b0;
            end
            S_FETCH: begin
                O_BUSY     = 1'b1;
                O_MEM_EN   = 1'b1;
                O_MEM_ADDR = base_q + idx_q;
            end
            S_DRAIN: O_BUSY = 1'b1;
            S_DONE:  O_DONE = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RSTN) begin
            base_q   <= '0;
            len_q    <= '0;
            win_q    <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (I_START) begin
                    base_q <= I_BASE;
                    len_q  <= I_LEN;
                    win_q  <= I_WINDOW;
                    if (degenerate) result_q <= '0;
                end
                S_CLR:   idx_q <= '0;
                S_FETCH: idx_q <= idx_q + ADDR_WIDTH'(1);
                S_DRAIN: if (I_CORE_LAST) result_q <= I_CORE_COUNT;
                default: ;
            endcase
        end
    end

    // Read data returns one cycle after each fetch; these flags track that return.
    always_ff @(posedge I_CLK) begin
        if (!I_RSTN) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q  <= (state == S_FETCH);
            rd_last_q <= (state == S_FETCH) && fetch_last;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RSTN) begin
            core_data_q <= '1;
            core_last_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            smp_cnt_q   <= '0;
        end else if (state == S_CLR) begin
            core_data_q <= '1;
            core_last_q <= 1'b0;
            smp_cnt_q   <= '0;
        end else begin
            core_last_q <= rd_vld_q && rd_last_q;
            if (rd_vld_q) begin
                s1_q <= I_MEM_DATA;
                s2_q <= s1_q;
                if (!win_q)
                    core_data_q <= I_MEM_DATA;
                else if (smp_cnt_q == 2'd2)
                    core_data_q <= s2_q + s1_q + I_MEM_DATA;
                if (smp_cnt_q != 2'd2) smp_cnt_q <= smp_cnt_q + 2'd1;
            end
        end
    end

    assign O_RESULT    = result_q;
    assign O_CORE_DATA = core_data_q;
    assign O_CORE_LAST = core_last_q;

endmodule

// File: tb/tb_depth_scan_ctrl.sv
// Self-checking bench for depth_scan_ctrl with a behavioural sample memory and
// counter core (counts strict increases, last flag delayed two cycles).
module tb_depth_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base = '0;
    logic [15:0] len = '0;
    logic        window = 1'b0;
    logic        busy, done, mem_en, core_rstn, core_last_o;
    logic [31:0] result, core_data;
    logic [15:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic [31:0] core_count = '0;
    logic [31:0] core_prev = '1;
    logic        core_l1 = 1'b0, core_l2 = 1'b0;

    logic [31:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    depth_scan_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .I_CLK(clk), .I_RSTN(rstn), .I_START(start), .I_BASE(base), .I_LEN(len),
        .I_WINDOW(window), .O_BUSY(busy), .O_DONE(done), .O_RESULT(result),
        .O_MEM_EN(mem_en), .O_MEM_ADDR(mem_addr), .I_MEM_DATA(mem_data),
        .O_CORE_RSTN(core_rstn), .O_CORE_DATA(core_data), .O_CORE_LAST(core_last_o),
        .I_CORE_COUNT(core_count), .I_CORE_LAST(core_l2)
    );

    always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

    always @(posedge clk) begin
        if (!core_rstn) begin
            core_count <= '0;
            core_prev  <= '1;
            core_l1    <= 1'b0;
            core_l2    <= 1'b0;
        end else begin
            if (core_data > core_prev) core_count <= core_count + 32'd1;
            core_prev <= core_data;
            core_l1   <= core_last_o;
            core_l2   <= core_l1;
        end
    end

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        logic        win;
        logic [31:0] data [10];
        logic [31:0] exp_result;
        int          exp_done;
        logic [31:0] exp_last_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int pulse_cycle);
        int          reads = 0, addr_err = 0, done_cyc = -1, done_cnt = 0, last_cyc = -1;
        logic [15:0] exp_addr;
        logic [31:0] last_data = '0;
        logic [31:0] prev_result;
        logic        degen;
        degen = (v.len == 0) || (v.win && v.len < 3);
        for (int i = 0; i < int'(v.len) && i < 10; i++) mem[16'(v.base + 16'(i))] = v.data[i];
        @(negedge clk);
        base = v.base; len = v.len; window = v.win; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        prev_result = result;
        for (int k = 1; k < int'(v.len) + 40; k++) begin
            if (k == 1 && !degen) check("core_rstn_in_clr", 32'(core_rstn), 32'd0);
            if (k == 2 && !degen) check("core_rstn_after_clr", 32'(core_rstn), 32'd1);
            if (k == 4 && !degen) check("busy_mid_job", 32'(busy), 32'd1);
            if (mem_en) begin
                exp_addr = v.base + 16'(reads);
                if (mem_addr !== exp_addr) addr_err++;
                reads++;
            end
            if (core_last_o) begin
                last_cyc  = k;
                last_data = core_data;
            end
            if (k == pulse_cycle) begin
                start = 1'b1; len = 16'd0; window = 1'b0;
            end
            if (k == pulse_cycle + 1) begin
                start = 1'b0;
                check("result_held_during_job", result, prev_result);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc >= 0 && k > done_cyc + 1) break;
            @(posedge clk); #1;
        end
        check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
        check("done_pulse_count", 32'(done_cnt), 32'd1);
        check("result", result, v.exp_result);
        check("read_count", 32'(reads), degen ? 32'd0 : 32'(v.len));
        check("read_addr_errors", 32'(addr_err), 32'd0);
        if (!degen) begin
            check("core_last_cycle", 32'(last_cyc), 32'(v.len) + 32'd3);
            check("core_last_data", last_data, v.exp_last_data);
        end
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{base: 16'd0, len: 16'd10, win: 1'b0,
                    data: '{199, 200, 208, 210, 200, 207, 240, 269, 260, 263},
                    exp_result: 32'd7, exp_done: 16, exp_last_data: 32'd263};
        vecs[1] = '{base: 16'd0, len: 16'd10, win: 1'b1,
                    data: '{199, 200, 208, 210, 200, 207, 240, 269, 260, 263},
                    exp_result: 32'd5, exp_done: 16, exp_last_data: 32'd792};
        vecs[2] = '{base: 16'd0, len: 16'd0, win: 1'b0, data: '{default: 0},
                    exp_result: 32'd0, exp_done: 1, exp_last_data: 32'd0};
        vecs[3] = '{base: 16'd0, len: 16'd2, win: 1'b1, data: '{default: 0},
                    exp_result: 32'd0, exp_done: 1, exp_last_data: 32'd0};
        vecs[4] = '{base: 16'hFFFE, len: 16'd4, win: 1'b0,
                    data: '{5, 4, 3, 2, 0, 0, 0, 0, 0, 0},
                    exp_result: 32'd0, exp_done: 10, exp_last_data: 32'd2};
        vecs[5] = '{base: 16'd100, len: 16'd3, win: 1'b0,
                    data: '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0},
                    exp_result: 32'd2, exp_done: 9, exp_last_data: 32'd3};
        vecs[6] = '{base: 16'd200, len: 16'd3, win: 1'b1,
                    data: '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0},
                    exp_result: 32'd0, exp_done: 9, exp_last_data: 32'hFFFFFFFD};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_core_data", core_data, 32'hFFFFFFFF);
        check("rst_core_last", 32'(core_last_o), 32'd0);
        check("rst_core_rstn", 32'(core_rstn), 32'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // vecs[0] first so the degenerate jobs clear a non-zero result.
        for (int i = 0; i < 7; i++) run_job(vecs[i], -1);

        // Start pulse mid-FETCH is ignored, then an immediate job shows the core was cleared.
        run_job(vecs[0], 4);
        run_job(vecs[1], -1);

        // Reset in the middle of FETCH.
        begin
            int dones = 0;
            @(negedge clk);
            base = 16'd0; len = 16'd10; window = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("fetch_before_reset", 32'(mem_en), 32'd1);
            rstn = 1'b0;
            @(posedge clk); #1;
            check("midrst_busy", 32'(busy), 32'd0);
            check("midrst_mem_en", 32'(mem_en), 32'd0);
            check("midrst_result", result, 32'd0);
            check("midrst_core_data", core_data, 32'hFFFFFFFF);
            check("midrst_core_rstn", 32'(core_rstn), 32'd0);
            if (done) dones++;
            rstn = 1'b1;
            repeat (20) begin
                @(posedge clk); #1;
                if (done || busy) dones++;
            end
            check("midrst_no_done", 32'(dones), 32'd0);
        end
        run_job(vecs[1], -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
